relu_stream_act: RTL and testbench
==================================

// Module: relu_stream_act
// PURPOSE
//  Multi-channel, pipelined activation unit for the CNN datapath; generalises the single-lane
//  16-bit ReLU. Applies a run-time-selected activation (bypass / ReLU / leaky ReLU / clipped
//  ReLU) to CH signed lanes per beat, with valid/ready flow control and frame marker. Sits between
//  the conv accumulator/requantiser and the max-pool stage.
// PARAMETERS
//  DATA_W      16  lane width, signed two's complement
//  CH          4   lanes per beat
//  LEAK_SHIFT  3   leaky-ReLU slope = 2^-LEAK_SHIFT (arithmetic right shift), 1..DATA_W-1
//  STAT_W      32  width of suppressed-lane counter (ACT_STATS_EN only)
// PORTS
//  clk          in   1          clock, all logic rising-edge
//  rst          in   1          reset, synchronous, active-high
//  cfg_mode     in   2          00 bypass, 01 ReLU, 10 leaky ReLU, 11 clipped ReLU
//  cfg_clip     in   DATA_W     signed clip ceiling for mode 11
//  in_valid     in   1          input beat valid
//  in_ready     out  1          unit can accept beat
//  in_data      in   CH*DATA_W  lanes, lane i at [i*DATA_W +: DATA_W]
//  in_last      in   1          last beat of frame
//  out_valid    out  1          output beat valid
//  out_ready    in   1          downstream accepts
//  out_data     out  CH*DATA_W  activated lanes
//  out_last     out  1          in_last delayed with its beat
//  stat_zero    out  STAT_W     lanes suppressed in last completed frame (ACT_STATS_EN)
//  stat_valid   out  1          1-cycle pulse when stat_zero updates (ACT_STATS_EN)
// BEHAVIOUR
//  - Transfer on valid&&ready at a rising edge, both sides. Throughput 1 beat/cycle.
//  - 2-stage pipeline: S1 registers in_data/in_last/cfg_mode/cfg_clip; S2 registers result.
//    Latency acceptance -> out_valid = 2 cycles with no back-pressure.
//  - cfg_mode/cfg_clip sampled at acceptance and travel with the beat; changing them mid-stream
//    affects only later-accepted beats.
//  - Stall: S2 advances if !s2_v || out_ready; S1 advances if !s1_v || S2 advances;
//    in_ready = !s1_v || S1 advances (combinational from out_ready). No beat lost or duplicated;
//    out_data/out_last held stable while out_valid && !out_ready.
//  - Per lane v (signed): bypass -> v; ReLU -> v<0 ? 0 : v; leaky -> v<0 ? v>>>LEAK_SHIFT : v
//    (rounds toward -inf, e.g. -1 -> -1); clipped -> v<0 ? 0 : (v>clip ? clip : v); if clip<0,
//    output 0 for all v. No overflow possible; output width = DATA_W.
//  - Boundary: v = -2^(DATA_W-1) -> 0 in ReLU/clip modes, = -2^(DATA_W-1-LEAK_SHIFT) in leaky.
//  - Reset: s1_v, s2_v, out_valid, out_last = 0; out_data = 0; in_ready = 1 from first
//    cycle after rst deasserts (0 while rst high). Reset mid-frame drops in-flight beats.
// CONFIGURATION
//  ACT_STATS_EN defined: counter adds, per output transfer, lanes with input != 0 and output == 0
//    (suppressed); on out_last transfer, stat_zero <= count incl. that beat, counter cleared,
//    stat_valid pulses 1 cycle. Counter saturates at all-ones. rst clears counter,
//    stat_zero=0, stat_valid=0. Stats never stall the datapath.
//  ACT_STATS_EN undefined: stat_zero/stat_valid ports and counter logic absent.
// STRUCTURE
//  - Package cnn_act_pkg: act_mode_e enum (ACT_BYPASS/RELU/LEAKY/CLIP), DATA_W/CH defaults.
//  - Sub-module relu_act_lane: combinational single-lane function (v, mode, clip -> y,
//    suppressed flag), instantiated CH times in a generate loop between S1 and S2.
// TESTING
//  1 ReLU, CH=4, lanes {-5,0,7,0x8000}, out_ready=1 -> 2 cycles later {0,0,7,0}.
//  2 Leaky LEAK_SHIFT=3, lanes {-16,-1,100,-32768} -> {-2,-1,100,-4096}.
//  3 Clip clip=6, {3,6,9,-2} -> {3,6,6,0}; clip=-1, {5,...} -> all 0.
//  4 Stream 20 beats, out_ready random 50% -> same 20 beats in order, out_data stable in stall,
//    in_ready low only when both stages full and out_ready=0.
//  5 Switch cfg_mode ReLU->bypass between beats 3 and 4 -> beats 0-3 ReLU, 4+ bypass.
//  6 ACT_STATS_EN: 3-beat frame with 5 negative lanes, ReLU -> stat_valid pulse, stat_zero=5;
//    assert rst mid-frame -> outputs/counter 0, next frame counts from 0.

Source files
------------

// File: rtl/cnn_act_pkg.sv
// cnn_act_pkg: activation mode encoding and default datapath sizes for the CNN activation stage
package cnn_act_pkg;
   localparam int DATA_W_DEF = 16;
   localparam int CH_DEF = 4;
   typedef enum logic [1:0] {ACT_BYPASS, ACT_RELU, ACT_LEAKY, ACT_CLIP} act_mode_e;
endpackage

// File: rtl/relu_act_lane.sv
// relu_act_lane: combinational single-lane activation with suppressed-lane flag
module relu_act_lane
   import cnn_act_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEAK_SHIFT = 3
) (
   input  logic signed [DATA_W-1:0] v,
   input  act_mode_e                mode,
   input  logic signed [DATA_W-1:0] clip,
   output logic signed [DATA_W-1:0] y,
   output logic                     sup
);
   logic signed [DATA_W-1:0] leak;
   logic neg;
   always_comb begin
      // kept in its own signed signal so the shift stays arithmetic
      leak = v >>> LEAK_SHIFT;
      neg = v[DATA_W-1];
      y = mode == ACT_BYPASS ? v :
          mode == ACT_RELU   ? (neg ? '0 : v) :
          mode == ACT_LEAKY  ? (neg ? leak : v) :
          (neg || clip[DATA_W-1]) ? '0 : (v > clip ? clip : v);
      sup = (v != '0) && (y == '0);
   end
endmodule

// File: rtl/relu_stream_act.sv
// relu_stream_act: 2-stage valid/ready multi-lane activation; ACT_STATS_EN adds suppressed-lane frame stats
module relu_stream_act
   import cnn_act_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CH = CH_DEF,
   parameter int LEAK_SHIFT = 3,
   parameter int STAT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           cfg_mode,
   input  logic [DATA_W-1:0]    cfg_clip,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*DATA_W-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH*DATA_W-1:0] out_data,
   output logic                 out_last
`ifdef ACT_STATS_EN
   ,
   output logic [STAT_W-1:0]    stat_zero,
   output logic                 stat_valid
`endif
);
   localparam int NW = $clog2(CH + 1);
   logic s1_v, s1_last, s2_v, s2_last, s1_adv, s2_adv;
   logic [CH*DATA_W-1:0] s1_data, s2_data, y;
   logic [DATA_W-1:0] s1_clip;
   act_mode_e s1_mode;
   logic [CH-1:0] sup;
   logic [NW-1:0] nsup, s2_nsup;
   always_comb begin
      s2_adv = !s2_v || out_ready;
      s1_adv = !s1_v || s2_adv;
      in_ready = !rst && s1_adv;
      nsup = '0;
      for (int i = 0; i < CH; i++) nsup = nsup + NW'(sup[i]);
   end
   assign out_valid = s2_v;
   assign out_data = s2_data;
   assign out_last = s2_last;
   genvar g;
   generate
      for (g = 0; g < CH; g++) begin : g_lane
         relu_act_lane #(.DATA_W(DATA_W), .LEAK_SHIFT(LEAK_SHIFT)) u_lane (
            .v(s1_data[g*DATA_W +: DATA_W]),
            .mode(s1_mode),
            .clip(s1_clip),
            .y(y[g*DATA_W +: DATA_W]),
            .sup(sup[g])
         );
      end
   endgenerate
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v <= 1'b0;
         s1_last <= 1'b0;
         s1_data <= '0;
         s1_clip <= '0;
         s1_mode <= ACT_BYPASS;
         s2_v <= 1'b0;
         s2_last <= 1'b0;
         s2_data <= '0;
         s2_nsup <= '0;
      end else begin
         if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
               s1_data <= in_data;
               s1_last <= in_last;
               s1_mode <= act_mode_e'(cfg_mode);
               s1_clip <= cfg_clip;
            end
         end
         if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
               s2_data <= y;
               s2_last <= s1_last;
               s2_nsup <= nsup;
            end
         end
      end
   end
`ifdef ACT_STATS_EN
   logic [STAT_W-1:0] cnt, cnt_sat;
   logic [STAT_W:0] sum;
   always_comb begin
      sum = {1'b0, cnt} + (STAT_W + 1)'(s2_nsup);
      cnt_sat = sum[STAT_W] ? '1 : sum[STAT_W-1:0];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         stat_zero <= '0;
         stat_valid <= 1'b0;
      end else begin
         stat_valid <= 1'b0;
         if (s2_v && out_ready) begin
            cnt <= s2_last ? '0 : cnt_sat;
            if (s2_last) begin
               stat_zero <= cnt_sat;
               stat_valid <= 1'b1;
            end
         end
      end
   end
`else
   logic unused_sup;
   assign unused_sup = ^{sup, s2_nsup};
`endif
endmodule

// File: tb/tb_relu_stream_act.sv
// tb_relu_stream_act: directed self-checking bench for relu_stream_act (ACT_STATS_EN checks when defined)
module tb_relu_stream_act;
   localparam int W = 16;
   localparam int C = 4;
   localparam int SW = 32;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] cfg_mode = 2'd0;
   logic [W-1:0] cfg_clip = '0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid, out_last;
   logic [C*W-1:0] in_data = '0, out_data;
`ifdef ACT_STATS_EN
   logic [SW-1:0] stat_zero, sv_val = '0;
   logic stat_valid;
   int sv_cnt = 0;
`endif
   int tests = 0, fails = 0, acc = 0, del = 0;
   logic [C*W:0] exp_q[$];
   logic [C*W:0] held = '0;
   bit rnd = 0, mon = 0, stalled = 0;

   always #5 clk = ~clk;

   relu_stream_act #(.DATA_W(W), .CH(C), .LEAK_SHIFT(3), .STAT_W(SW)) dut (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_clip(cfg_clip),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
`ifdef ACT_STATS_EN
      , .stat_zero(stat_zero), .stat_valid(stat_valid)
`endif
   );

   task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [C*W-1:0] pk(int a, int b, int c, int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   always @(posedge clk) begin
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
   end

   // scoreboard: transfers are judged at the falling edge before the rising edge that commits them
   always @(negedge clk) begin
      if (rst) begin
         acc = 0;
         del = 0;
         stalled = 0;
      end else if (mon) begin
         check("in_ready", in_ready, !((acc - del) == 2 && !out_ready));
         if (stalled) check("hold", {out_last, out_data}, held);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("extra_beat", out_valid, 1'b0);
            else check("beat", {out_last, out_data}, exp_q.pop_front());
            del++;
         end
         if (in_valid && in_ready) acc++;
         stalled = out_valid && !out_ready;
         held = {out_last, out_data};
`ifdef ACT_STATS_EN
         if (stat_valid) begin
            sv_cnt++;
            sv_val = stat_zero;
         end
`endif
      end
   end

   task automatic send(logic [1:0] m, logic [W-1:0] clip, logic [C*W-1:0] d, logic last,
                       logic [C*W-1:0] e);
      logic ok;
      cfg_mode = m;
      cfg_clip = clip;
      in_data = d;
      in_last = last;
      in_valid = 1'b1;
      exp_q.push_back({last, e});
      for (int n = 0; ; n++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
         if (n > 200) begin
            check("send_timeout", ok, 1'b1);
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(posedge clk);
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

`ifdef ACT_STATS_EN
   task automatic wait_stat(logic [SW-1:0] exp);
      int c0;
      c0 = sv_cnt;
      for (int n = 0; n < 50 && sv_cnt == c0; n++) @(posedge clk);
      repeat (3) @(posedge clk);
      check("stat_pulse", sv_cnt, c0 + 1);
      check("stat_zero", sv_val, exp);
      #1;
   endtask
`endif

   initial begin
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      mon = 1;
      @(posedge clk);
      #1;
      // ReLU including the most negative value, with latency check
      send(2'd1, '0, pk(-5, 0, 7, -32768), 1'b0, pk(0, 0, 7, 0));
      @(negedge clk);
      check("lat_1cyc", out_valid, 1'b0);
      @(negedge clk);
      check("lat_2cyc", out_valid, 1'b1);
      @(posedge clk);
      #1;
      send(2'd2, '0, pk(-16, -1, 100, -32768), 1'b0, pk(-2, -1, 100, -4096));
      send(2'd3, 16'd6, pk(3, 6, 9, -2), 1'b0, pk(3, 6, 6, 0));
      send(2'd3, 16'hffff, pk(5, 0, -3, 32767), 1'b1, pk(0, 0, 0, 0));
      send(2'd0, '0, pk(-7, 1, -32768, 32767), 1'b0, pk(-7, 1, -32768, 32767));
      drain();
      // streaming under random back-pressure
      rnd = 1;
      for (int i = 0; i < 20; i++)
         send(2'd1, '0, pk(i, -i - 1, 100 + i, -100 - i), 1'(i == 19), pk(i, 0, 100 + i, 0));
      drain();
      // mode switch between beats 3 and 4 while earlier beats are still in flight
      for (int i = 0; i < 8; i++)
         send(i < 4 ? 2'd1 : 2'd0, '0, pk(-1 - i, -2, 3 + i, -4), 1'(i == 7),
              i < 4 ? pk(0, 0, 3 + i, 0) : pk(-1 - i, -2, 3 + i, -4));
      drain();
      rnd = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
`ifdef ACT_STATS_EN
      send(2'd1, '0, pk(-1, -2, 0, 3), 1'b0, pk(0, 0, 0, 3));
      send(2'd1, '0, pk(-3, 0, 0, 0), 1'b0, pk(0, 0, 0, 0));
      send(2'd1, '0, pk(5, -4, -5, 0), 1'b1, pk(5, 0, 0, 0));
      drain();
      wait_stat(5);
      send(2'd1, '0, pk(-1, -2, 0, 0), 1'b0, pk(0, 0, 0, 0));
      drain();
      out_ready = 1'b0;
      send(2'd1, '0, pk(-9, -9, -9, -9), 1'b0, pk(0, 0, 0, 0));
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_data", out_data, '0);
      check("midrst_stat_zero", stat_zero, '0);
      check("midrst_stat_valid", stat_valid, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      send(2'd1, '0, pk(-1, 0, 0, 0), 1'b1, pk(0, 0, 0, 0));
      drain();
      wait_stat(1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
